// File: rtl/cog_deadtime_v1_pkg.sv
// COG register layouts and field masks shared by the wrapper and its SFR instances.
// The shdn_flag bit is only implemented when COG_AUTO_SHUTDOWN_EN is defined.
package pkg_sfrs_definition;

   typedef struct packed {
      logic [27:0] rsvd;
      logic        shdn_flag;
      logic        pol_l;
      logic        pol_h;
      logic        en;
   } cog_ctrl_t;

   typedef struct packed {
      logic [15:0] rsvd;
      logic [7:0]  dt_fall;
      logic [7:0]  dt_rise;
   } cog_dt_t;

   localparam logic [31:0] COG_CTRL_IMPL_MASK = 32'h0000_000F;
   localparam logic [31:0] COG_CTRL_HW_MASK   = 32'h0000_0008;
   localparam logic [31:0] COG_DT_IMPL_MASK   = 32'h0000_FFFF;
   localparam logic [31:0] COG_DT_HW_MASK     = 32'h0000_0000;
   localparam int unsigned COG_DT_OFFSET      = 4;

endpackage

// File: rtl/cog_core_v1.sv
// COG datapath: PWM input register, dead-band FSM/counter, registered outputs.
// The SHDN state exists only when COG_AUTO_SHUTDOWN_EN is defined.
module cog_core_v1 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clk_en,
   input  logic       i_en,
   input  logic       i_pol_h,
   input  logic       i_pol_l,
   input  logic [7:0] i_dt_rise,
   input  logic [7:0] i_dt_fall,
   input  logic       i_pwm,
`ifdef COG_AUTO_SHUTDOWN_EN
   input  logic       i_shdn_in,
   input  logic       i_shdn_flag,
`endif
   output logic       o_cog_h,
   output logic       o_cog_l
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_H_ON,
      ST_L_ON,
      ST_DT_RISE,
      ST_DT_FALL
`ifdef COG_AUTO_SHUTDOWN_EN
      , ST_SHDN
`endif
   } state_t;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_pwm_q;
   logic       r_cog_h;
   logic       r_cog_l;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pwm_q <= 1'b0;
         r_cog_h <= 1'b0;
         r_cog_l <= 1'b0;
      end else if (i_clk_en) begin
         r_pwm_q <= i_pwm;
         r_cog_h <= (r_state == ST_H_ON) ^ i_pol_h;
         r_cog_l <= (r_state == ST_L_ON) ^ i_pol_l;
`ifdef COG_AUTO_SHUTDOWN_EN
         if (r_state != ST_SHDN && i_en && i_shdn_in) begin
            r_state <= ST_SHDN;
            r_cnt   <= '0;
         end else if (r_state == ST_SHDN) begin
            if (!i_shdn_flag && !i_shdn_in)
               r_state <= ST_IDLE;
         end else
`endif
         if (!i_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  // the band is also applied when leaving IDLE
                  if (r_pwm_q) begin
                     r_state <= ST_DT_RISE;
                     r_cnt   <= i_dt_rise;
                  end else begin
                     r_state <= ST_DT_FALL;
                     r_cnt   <= i_dt_fall;
                  end
               end
               ST_H_ON: begin
                  if (!r_pwm_q) begin
                     if (i_dt_fall == 8'd0) begin
                        r_state <= ST_L_ON;
                     end else begin
                        r_state <= ST_DT_FALL;
                        r_cnt   <= i_dt_fall;
                     end
                  end
               end
               ST_L_ON: begin
                  if (r_pwm_q) begin
                     if (i_dt_rise == 8'd0) begin
                        r_state <= ST_H_ON;
                     end else begin
                        r_state <= ST_DT_RISE;
                        r_cnt   <= i_dt_rise;
                     end
                  end
               end
               ST_DT_RISE: begin
                  if (!r_pwm_q) begin
                     r_state <= ST_L_ON;
                     r_cnt   <= '0;
                  end else if (r_cnt <= 8'd1) begin
                     r_state <= ST_H_ON;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt - 8'd1;
                  end
               end
               ST_DT_FALL: begin
                  if (r_pwm_q) begin
                     r_state <= ST_H_ON;
                     r_cnt   <= '0;
                  end else if (r_cnt <= 8'd1) begin
                     r_state <= ST_L_ON;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt - 8'd1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign o_cog_h = r_cog_h;
   assign o_cog_l = r_cog_l;

endmodule

// File: rtl/sfr_module_v1.sv
// Generic memory-mapped SFR: software write, hardware sticky-set, masked read.
// A hardware set on the same edge as a software write wins.
module sfr_module_v1 #(
   parameter int unsigned                  DATA_WIDTH = 32,
   parameter int unsigned                  ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]        ADDR       = '0,
   parameter logic [DATA_WIDTH-1:0]        IMPL_MASK  = '1,
   parameter logic [DATA_WIDTH-1:0]        HW_MASK    = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clk_en,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_hw_set,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [DATA_WIDTH-1:0] o_q
);

   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_next;
   logic [DATA_WIDTH-1:0] r_q;

   assign w_hit  = (i_addr == ADDR);
   assign w_next = ((w_hit && i_wr_en) ? i_wdata : r_q)
                 | (i_hw_set & HW_MASK);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_clk_en) begin
         r_q <= w_next & IMPL_MASK;
      end
   end

   assign o_rd_data = w_hit ? r_q : '0;
   assign o_q       = r_q;

endmodule

// File: rtl/cog_deadtime_v1.sv
// Complementary output generator wrapper: COG_CTRL/COG_DT SFRs plus core.
// Define COG_AUTO_SHUTDOWN_EN to build the latched fault shutdown.
module cog_deadtime_v1
   import pkg_sfrs_definition::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  sys_clk_en,
   input  logic [ADDR_WIDTH-1:0] sys_addr,
   input  logic                  sys_wr_en,
   input  logic [DATA_WIDTH-1:0] sys_sw_value,
   input  logic                  pwm_in,
   input  logic                  shdn_in,
   output logic [DATA_WIDTH-1:0] sfr_rd_dout,
   output logic                  cog_h,
   output logic                  cog_l
);

   localparam logic [ADDR_WIDTH-1:0] LP_CTRL_ADDR =
      ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LP_DT_ADDR =
      ADDR_WIDTH'(BASE_ADDR + COG_DT_OFFSET);
   localparam logic [DATA_WIDTH-1:0] LP_HW_MASK =
      DATA_WIDTH'(COG_CTRL_HW_MASK);
`ifdef COG_AUTO_SHUTDOWN_EN
   localparam logic [DATA_WIDTH-1:0] LP_CTRL_MASK =
      DATA_WIDTH'(COG_CTRL_IMPL_MASK);
`else
   localparam logic [DATA_WIDTH-1:0] LP_CTRL_MASK =
      DATA_WIDTH'(COG_CTRL_IMPL_MASK & ~COG_CTRL_HW_MASK);
`endif

   logic [DATA_WIDTH-1:0] w_ctrl_q;
   logic [DATA_WIDTH-1:0] w_dt_q;
   logic [DATA_WIDTH-1:0] w_ctrl_rd;
   logic [DATA_WIDTH-1:0] w_dt_rd;
   logic [DATA_WIDTH-1:0] w_ctrl_wdata;
   logic [DATA_WIDTH-1:0] w_ctrl_hw;
   cog_ctrl_t             w_ctrl;
   cog_dt_t               w_dt;
   logic                  w_unused;

   assign w_ctrl = cog_ctrl_t'(w_ctrl_q[31:0]);
   assign w_dt   = cog_dt_t'(w_dt_q[31:0]);

   // software may only clear hardware-set bits, never set them
   assign w_ctrl_wdata = sys_sw_value & ~(LP_HW_MASK & ~w_ctrl_q);

   always_comb begin
      w_ctrl_hw = '0;
`ifdef COG_AUTO_SHUTDOWN_EN
      w_ctrl_hw[3] = shdn_in & w_ctrl.en;
`endif
   end

   sfr_module_v1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR       (LP_CTRL_ADDR),
      .IMPL_MASK  (LP_CTRL_MASK),
      .HW_MASK    (LP_HW_MASK)
   ) u_ctrl (
      .i_clk      (sys_clk),
      .i_rst_n    (sys_rst_n),
      .i_clk_en   (sys_clk_en),
      .i_addr     (sys_addr),
      .i_wr_en    (sys_wr_en),
      .i_wdata    (w_ctrl_wdata),
      .i_hw_set   (w_ctrl_hw),
      .o_rd_data  (w_ctrl_rd),
      .o_q        (w_ctrl_q)
   );

   sfr_module_v1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR       (LP_DT_ADDR),
      .IMPL_MASK  (DATA_WIDTH'(COG_DT_IMPL_MASK)),
      .HW_MASK    (DATA_WIDTH'(COG_DT_HW_MASK))
   ) u_dt (
      .i_clk      (sys_clk),
      .i_rst_n    (sys_rst_n),
      .i_clk_en   (sys_clk_en),
      .i_addr     (sys_addr),
      .i_wr_en    (sys_wr_en),
      .i_wdata    (sys_sw_value),
      .i_hw_set   ('0),
      .o_rd_data  (w_dt_rd),
      .o_q        (w_dt_q)
   );

   cog_core_v1 u_core (
      .i_clk       (sys_clk),
      .i_rst_n     (sys_rst_n),
      .i_clk_en    (sys_clk_en),
      .i_en        (w_ctrl.en),
      .i_pol_h     (w_ctrl.pol_h),
      .i_pol_l     (w_ctrl.pol_l),
      .i_dt_rise   (w_dt.dt_rise),
      .i_dt_fall   (w_dt.dt_fall),
      .i_pwm       (pwm_in),
`ifdef COG_AUTO_SHUTDOWN_EN
      .i_shdn_in   (shdn_in),
      .i_shdn_flag (w_ctrl.shdn_flag),
`endif
      .o_cog_h     (cog_h),
      .o_cog_l     (cog_l)
   );

   assign sfr_rd_dout = w_ctrl_rd | w_dt_rd;

   assign w_unused = ^{shdn_in, w_ctrl.rsvd, w_ctrl.shdn_flag,
                       w_dt.rsvd};

endmodule

// File: tb/tb_cog_deadtime_v1.sv
// Directed testbench for cog_deadtime_v1 (dead bands, polarity, SFRs, shutdown).
// Build with or without COG_AUTO_SHUTDOWN_EN; the shutdown task adapts.
module tb_cog_deadtime_v1;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int BASE = 0;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          sys_clk_en;
   logic [AW-1:0] sys_addr;
   logic          sys_wr_en;
   logic [DW-1:0] sys_sw_value;
   logic          pwm_in;
   logic          shdn_in;
   logic [DW-1:0] sfr_rd_dout;
   logic          cog_h;
   logic          cog_l;

   int n_cmp = 0;
   int n_bad = 0;

   cog_deadtime_v1 #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .sys_clk_en   (sys_clk_en),
      .sys_addr     (sys_addr),
      .sys_wr_en    (sys_wr_en),
      .sys_sw_value (sys_sw_value),
      .pwm_in       (pwm_in),
      .shdn_in      (shdn_in),
      .sfr_rd_dout  (sfr_rd_dout),
      .cog_h        (cog_h),
      .cog_l        (cog_l)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      sys_addr     = a;
      sys_sw_value = d;
      sys_wr_en    = 1'b1;
      tick();
      sys_wr_en    = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_out: got h=%b l=%b want 0 0", cog_h, cog_l);
      end
      sys_addr = AW'(BASE);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %h want 0", sfr_rd_dout);
      end
      sys_addr = AW'(BASE + 4);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_dt: got %h want 0", sfr_rd_dout);
      end
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_deadband();
      logic eh, el;
      wr(AW'(BASE + 4), 32'h0000_0503);
      pwm_in = 1'b0;
      wr(AW'(BASE), 32'h1);
      repeat (7) tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b01) begin
         n_bad++;
         $display("FAIL db_entry: got h=%b l=%b want 0 1", cog_h, cog_l);
      end
      pwm_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         eh = (k >= 5);
         el = (k < 2);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL db_rise N+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
      end
      pwm_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         eh = (k < 2);
         el = (k >= 7);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL db_fall M+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
      end
   endtask

   task automatic test_zero_dt();
      logic eh, el;
      wr(AW'(BASE + 4), 32'h0);
      pwm_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         eh = (k >= 2);
         el = (k < 2);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL zdt_rise N+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
      end
      pwm_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         eh = (k < 2);
         el = (k >= 2);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL zdt_fall M+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
      end
   endtask

   task automatic test_abort();
      logic el;
      wr(AW'(BASE + 4), 32'h0000_000A);
      pwm_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         el = (k < 2) || (k >= 6);
         n_cmp++;
         if ({cog_h, cog_l} !== {1'b0, el}) begin
            n_bad++;
            $display("FAIL abort N+%0d: got h=%b l=%b want 0 %b",
                     k, cog_h, cog_l, el);
         end
         if (k == 3) pwm_in = 1'b0;
      end
   endtask

   task automatic test_midband_write();
      logic eh, el;
      wr(AW'(BASE + 4), 32'h0000_0004);
      pwm_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         eh = (k >= 6);
         el = (k < 2);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL midwr N+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
         if (k == 1) begin
            sys_addr     = AW'(BASE + 4);
            sys_sw_value = 32'h0000_0001;
            sys_wr_en    = 1'b1;
         end
         if (k == 2) sys_wr_en = 1'b0;
      end
      sys_addr = AW'(BASE + 4);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0001) begin
         n_bad++;
         $display("FAIL midwr_rd: got %h want 00000001", sfr_rd_dout);
      end
   endtask

   task automatic test_read();
      wr(AW'(BASE), 32'hFFFF_FFF7);
      sys_addr = AW'(BASE);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0007) begin
         n_bad++;
         $display("FAIL rd_ctrl: got %h want 00000007", sfr_rd_dout);
      end
      wr(AW'(BASE + 4), 32'hFFFF_0202);
      sys_addr = AW'(BASE + 4);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0202) begin
         n_bad++;
         $display("FAIL rd_dt: got %h want 00000202", sfr_rd_dout);
      end
      sys_addr = AW'(BASE + 8);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0) begin
         n_bad++;
         $display("FAIL rd_nomatch: got %h want 0", sfr_rd_dout);
      end
   endtask

   task automatic test_polarity();
      logic eh;
      wr(AW'(BASE), 32'h6);
      tick();
      tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b11) begin
         n_bad++;
         $display("FAIL pol_dis: got h=%b l=%b want 1 1", cog_h, cog_l);
      end
      wr(AW'(BASE + 4), 32'h0000_0002);
      wr(AW'(BASE), 32'h7);
      for (int k = 1; k <= 4; k++) begin
         tick();
         eh = (k < 4);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, 1'b1}) begin
            n_bad++;
            $display("FAIL pol_en E+%0d: got h=%b l=%b want %b 1",
                     k, cog_h, cog_l, eh);
         end
      end
   endtask

   task automatic test_clk_en();
      logic eh, el;
      wr(AW'(BASE), 32'h1);
      wr(AW'(BASE + 4), 32'h0000_0303);
      tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b10) begin
         n_bad++;
         $display("FAIL ce_pre: got h=%b l=%b want 1 0", cog_h, cog_l);
      end
      sys_clk_en   = 1'b0;
      pwm_in       = 1'b0;
      sys_addr     = AW'(BASE + 4);
      sys_sw_value = 32'h0;
      sys_wr_en    = 1'b1;
      repeat (6) tick();
      sys_wr_en = 1'b0;
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b10) begin
         n_bad++;
         $display("FAIL ce_hold: got h=%b l=%b want 1 0", cog_h, cog_l);
      end
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0303) begin
         n_bad++;
         $display("FAIL ce_sfr: got %h want 00000303", sfr_rd_dout);
      end
      sys_clk_en = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         eh = (k < 2);
         el = (k >= 5);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, el}) begin
            n_bad++;
            $display("FAIL ce_run M+%0d: got h=%b l=%b want %b %b",
                     k, cog_h, cog_l, eh, el);
         end
      end
   endtask

   task automatic test_shutdown();
      logic eh;
      pwm_in = 1'b1;
      repeat (8) tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b10) begin
         n_bad++;
         $display("FAIL sd_pre: got h=%b l=%b want 1 0", cog_h, cog_l);
      end
      sys_addr = AW'(BASE);
`ifdef COG_AUTO_SHUTDOWN_EN
      shdn_in = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({cog_h, cog_l} !== 2'b00) begin
         n_bad++;
         $display("FAIL sd_out: got h=%b l=%b want 0 0", cog_h, cog_l);
      end
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0009) begin
         n_bad++;
         $display("FAIL sd_flag: got %h want 00000009", sfr_rd_dout);
      end
      wr(AW'(BASE), 32'h1);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0009) begin
         n_bad++;
         $display("FAIL sd_setwins: got %h want 00000009", sfr_rd_dout);
      end
      shdn_in = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({cog_h, cog_l, sfr_rd_dout} !== {2'b00, 32'h0000_0009}) begin
         n_bad++;
         $display("FAIL sd_latched: got h=%b l=%b rd=%h want 0 0 00000009",
                  cog_h, cog_l, sfr_rd_dout);
      end
      wr(AW'(BASE), 32'h1);
      #1;
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0001) begin
         n_bad++;
         $display("FAIL sd_clear: got %h want 00000001", sfr_rd_dout);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         eh = (k >= 6);
         n_cmp++;
         if ({cog_h, cog_l} !== {eh, 1'b0}) begin
            n_bad++;
            $display("FAIL sd_resume C+%0d: got h=%b l=%b want %b 0",
                     k, cog_h, cog_l, eh);
         end
      end
`else
      shdn_in = 1'b1;
      repeat (3) tick();
      eh = 1'b1;
      n_cmp++;
      if ({cog_h, cog_l} !== {eh, 1'b0}) begin
         n_bad++;
         $display("FAIL sd_ignored: got h=%b l=%b want 1 0", cog_h, cog_l);
      end
      n_cmp++;
      if (sfr_rd_dout !== 32'h0000_0001) begin
         n_bad++;
         $display("FAIL sd_noflag: got %h want 00000001", sfr_rd_dout);
      end
      shdn_in = 1'b0;
`endif
   endtask

   initial begin
      sys_rst_n    = 1'b0;
      sys_clk_en   = 1'b1;
      sys_addr     = '0;
      sys_wr_en    = 1'b0;
      sys_sw_value = '0;
      pwm_in       = 1'b0;
      shdn_in      = 1'b0;
      test_reset();
      test_deadband();
      test_zero_dt();
      test_abort();
      test_midband_write();
      test_read();
      test_polarity();
      test_clk_en();
      test_shutdown();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
